// File: rtl/perm_pkg.sv
// Shared types and defaults for the permutation-table sequencer.
package perm_pkg;
  localparam int DEF_W         = 8;
  localparam int DEF_N         = 1 << DEF_W;
  localparam int DEF_MAX_TRIES = 4096;
  localparam int DEF_CNT_W     = 16;

  typedef enum logic [1:0] {IDLE, COLLECT, FILL, DONE} state_e;
endpackage

// File: rtl/perm_used_bitmap.sv
// One flag per table symbol: marks values already written into the permutation.
module perm_used_bitmap #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         set,
  input  logic [W-1:0] idx,
  output logic         used
);
  localparam int N = 1 << W;

  logic [N-1:0] bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      bits <= '0;
    else if (clr) bits <= '0;
    else if (set) bits[idx] <= 1'b1;
  end

  // Lookup and set share one index: a value is tested and claimed in the same cycle.
  assign used = bits[idx];
endmodule

// File: rtl/perm_gen_ctrl.sv
// Builds a 2^W-entry permutation from a candidate stream, dropping repeats and
// completing the table by ascending scan if the stream times out.
module perm_gen_ctrl
  import perm_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cand_valid,
  input  logic [W-1:0]     cand_data,
  output logic             cand_ready,
  output logic             tbl_we,
  output logic [W-1:0]     tbl_addr,
  output logic [W-1:0]     tbl_data,
  output logic             busy,
  output logic             perm_done,
  output logic [CNT_W-1:0] dup_count,
  output logic [W:0]       fill_count
);
  localparam int N     = 1 << W;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e           state;
  logic [W:0]       wr_cnt;
  logic [TRY_W-1:0] try_cnt;
  logic [W-1:0]     scan;
  logic [W-1:0]     lk_idx;
  logic             used_hit;
  logic             hs;
  logic             last_wr;
  logic             bm_set;
  logic             bm_clr;

  assign hs      = cand_valid & cand_ready;
  assign lk_idx  = (state == FILL) ? scan : cand_data;
  assign last_wr = (wr_cnt == (W+1)'(N - 1));
  assign bm_clr  = (state == IDLE) && start;
  assign bm_set  = ((state == COLLECT) && hs && !used_hit) || ((state == FILL) && !used_hit);

  perm_used_bitmap #(.W(W)) u_used (
    .clk  (clk),
    .rst  (rst),
    .clr  (bm_clr),
    .set  (bm_set),
    .idx  (lk_idx),
    .used (used_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      try_cnt    <= '0;
      scan       <= '0;
      cand_ready <= 1'b0;
      tbl_we     <= 1'b0;
      tbl_addr   <= '0;
      tbl_data   <= '0;
      busy       <= 1'b0;
      perm_done  <= 1'b0;
      dup_count  <= '0;
      fill_count <= '0;
    end else begin
      tbl_we    <= 1'b0;
      perm_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wr_cnt     <= '0;
          try_cnt    <= '0;
          scan       <= '0;
          dup_count  <= '0;
          fill_count <= '0;
          busy       <= 1'b1;
          cand_ready <= 1'b1;
          state      <= COLLECT;
        end
        COLLECT: if (hs) begin
          try_cnt <= try_cnt + 1'b1;
          if (!used_hit) begin
            tbl_we   <= 1'b1;
            tbl_addr <= wr_cnt[W-1:0];
            tbl_data <= cand_data;
            wr_cnt   <= wr_cnt + 1'b1;
          end else if (dup_count != '1) begin
            dup_count <= dup_count + 1'b1;
          end
          // Completing the table wins over running out of tries on the same handshake.
          if (!used_hit && last_wr) begin
            cand_ready <= 1'b0;
            state      <= DONE;
          end else if (try_cnt == TRY_W'(MAX_TRIES - 1)) begin
            cand_ready <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          scan <= scan + 1'b1;
          if (!used_hit) begin
            tbl_we     <= 1'b1;
            tbl_addr   <= wr_cnt[W-1:0];
            tbl_data   <= scan;
            wr_cnt     <= wr_cnt + 1'b1;
            fill_count <= fill_count + 1'b1;
            if (last_wr) state <= DONE;
          end
        end
        DONE: begin
          perm_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perm_gen_ctrl.sv
// Randomized bench for perm_gen_ctrl against a queue-based model of the expected write stream.
module tb_perm_gen_ctrl;
  localparam int W     = 8;
  localparam int N     = 1 << W;
  localparam int MAXT  = 4096;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cand_valid;
  logic [W-1:0]     cand_data;
  logic             cand_ready;
  logic             tbl_we;
  logic [W-1:0]     tbl_addr;
  logic [W-1:0]     tbl_data;
  logic             busy;
  logic             perm_done;
  logic [CNT_W-1:0] dup_count;
  logic [W:0]       fill_count;

  perm_gen_ctrl #(.W(W), .MAX_TRIES(MAXT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cand_valid (cand_valid),
    .cand_data  (cand_data),
    .cand_ready (cand_ready),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .busy       (busy),
    .perm_done  (perm_done),
    .dup_count  (dup_count),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: set of used symbols plus the ordered list of writes the run must produce.
  bit used [N];
  int exp_q[$];
  int m_wr, m_tries, m_dups, m_fills, done_cnt, n_writes;
  bit collecting, run_active, prev_we;

  function automatic void model_clear();
    foreach (used[i]) used[i] = 1'b0;
    exp_q.delete();
    m_wr = 0; m_tries = 0; m_dups = 0; m_fills = 0;
    done_cnt = 0; n_writes = 0;
  endfunction

  function automatic void model_fill();
    for (int s = 0; s < N; s++)
      if (!used[s]) begin
        used[s] = 1'b1;
        exp_q.push_back(m_wr * N + s);
        m_wr++;
        m_fills++;
      end
  endfunction

  // One clock: check what the DUT shows now, apply new inputs, let the model consume them.
  task automatic cyc(input bit v, input bit [W-1:0] d, input bit st);
    if (tbl_we) begin
      n_writes++;
      if (exp_q.size() == 0) chk("extra_write", 1, 0);
      else begin
        int e;
        e = exp_q.pop_front();
        chk("wr_addr", tbl_addr, e / N);
        chk("wr_data", tbl_data, e % N);
      end
    end
    if (perm_done) begin
      done_cnt++;
      run_active = 1'b0;
      chk("done_after_last_we", prev_we, 1);
      chk("done_pending_writes", exp_q.size(), 0);
    end
    chk("busy", busy, run_active);
    chk("cand_ready", cand_ready, collecting);
    chk("dup_count", dup_count, m_dups);
    prev_we = tbl_we;

    start = st; cand_valid = v; cand_data = d;
    if (collecting && v) begin
      m_tries++;
      if (!used[d]) begin
        used[d] = 1'b1;
        exp_q.push_back(m_wr * N + d);
        m_wr++;
      end else if (m_dups < (1 << CNT_W) - 1) m_dups++;
      if (m_wr == N) collecting = 1'b0;
      else if (m_tries == MAXT) begin
        collecting = 1'b0;
        model_fill();
      end
    end else if (st && !run_active) begin
      model_clear();
      collecting = 1'b1;
      run_active = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    cyc(1'b0, '0, 1'b1);
  endtask

  task automatic finish_run(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      cyc(1'b0, '0, 1'b0);
      k++;
    end
    chk("done_seen", done_cnt, 1);
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("done_once", done_cnt, 1);
    chk("n_writes", n_writes, N);
    chk("fill_count", fill_count, m_fills);
    chk("dup_hold", dup_count, m_dups);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; cand_valid = 1'b0; cand_data = '0;
    collecting = 1'b0; run_active = 1'b0; prev_we = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    chk("rst_cand_ready", cand_ready, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perm_done", perm_done, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_tbl_data", tbl_data, 0);
    chk("rst_dup", dup_count, 0);
    chk("rst_fill", fill_count, 0);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);

    // Ascending stream
    do_start();
    for (int i = 0; i < N; i++) cyc(1'b1, W'(i), 1'b0);
    finish_run(20);
    chk("asc_fill_zero", fill_count, 0);
    chk("asc_dup_zero", dup_count, 0);

    // Early duplicates
    do_start();
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'd7, 1'b0);
    cyc(1'b1, 8'd5, 1'b0);
    chk("dup_after4", dup_count, 2);
    for (int i = 0; i < N; i++)
      if (i != 5 && i != 7) cyc(1'b1, W'(i), 1'b0);
    finish_run(20);

    // Constant stream forces the fill path
    do_start();
    for (int i = 0; i < MAXT + 4; i++) cyc(1'b1, 8'd3, 1'b0);
    finish_run(N + 20);
    chk("fill_255", fill_count, N - 1);
    chk("dup_const", dup_count, MAXT - 1);

    // Valid every other cycle, random data
    do_start();
    for (int k = 0; k < 3 * MAXT && done_cnt == 0; k++)
      cyc(k[0], W'($urandom_range(0, N - 1)), 1'b0);
    finish_run(N + 20);

    // start during COLLECT is ignored
    do_start();
    for (int i = 20; i < 30; i++) cyc(1'b1, W'(i), 1'b0);
    cyc(1'b1, 8'd20, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b1, 8'd21, 1'b1);
    for (int i = 0; i < N; i++) cyc(1'b1, W'(i), 1'b0);
    finish_run(20);

    // Reset mid-run aborts; the next run starts from a cleared bitmap
    do_start();
    for (int i = 0; i < 10; i++) cyc(1'b1, W'(100 + i), 1'b0);
    rst = 1'b1;
    model_clear();
    collecting = 1'b0; run_active = 1'b0; prev_we = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_we", tbl_we, 0);
    cyc(1'b1, 8'd50, 1'b0);
    cyc(1'b1, 8'd51, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(60 + i), 1'b0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_write", n_writes, 0);
    do_start();
    cyc(1'b1, 8'd0, 1'b0);
    chk("restart_addr0_we", tbl_we, 1);
    for (int i = 1; i < N; i++) cyc(1'b1, W'(N - i), 1'b0);
    finish_run(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
